// File: rtl/debug_display_pkg.sv
// Shared encodings and constants for the debug seven-segment display.
package debug_display_pkg;

    // Source select encodings.
    typedef enum logic [2:0] {
        SEL_PC      = 3'd0,
        SEL_INSTR   = 3'd1,
        SEL_R0      = 3'd2,
        SEL_R2      = 3'd3,
        SEL_R3      = 3'd4,
        SEL_R4      = 3'd5,
        SEL_RETIRED = 3'd6,
        SEL_BLANK   = 3'd7
    } sel_e;

    // Prescaler width covers the largest legal refresh divider (2^20).
    localparam int unsigned PRESC_W = 20;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Hex digit to active-low gfedcba segments.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/debug_display_hex_to_seven_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seven_seg
    import debug_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        o_seg = HEX_SEG[i_nibble];
    end

endmodule

// File: rtl/debug_display.sv
// Debug display: snapshots a selected 32-bit tap once per refresh frame and
// scans it out in hex on an 8-digit multiplexed seven-segment display.
module debug_display
    import debug_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  Sel,
    input  logic        Freeze,
    input  logic [31:0] pc_debug,
    input  logic [31:0] instruction_debug,
    input  logic [31:0] debug_reg_0,
    input  logic [31:0] debug_reg_2,
    input  logic [31:0] debug_reg_3,
    input  logic [31:0] debug_reg_4,
    output logic [6:0]  Seg,
    output logic [7:0]  An,
    output logic        Dp
);

    logic [PRESC_W-1:0] r_presc;
    logic [2:0]         r_idx;
    logic [31:0]        r_snap;
    logic [31:0]        r_retired;
    logic [31:0]        r_prev_pc;
    logic [6:0]         r_seg;
    logic [7:0]         r_an;
    logic               r_dp;

    logic               w_tick;
    logic               w_frame;
    logic [31:0]        w_sel_val;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg;

    // Tick at the last count of each digit slot; frame ends on the last digit.
    always_comb begin
        w_tick  = (r_presc == PRESC_W'(REFRESH_DIV - 1));
        w_frame = w_tick && (r_idx == 3'd7);
    end

    // Source mux for the snapshot; blank select loads zero.
    always_comb begin
        w_sel_val = 32'h0;
        unique case (sel_e'(Sel))
            SEL_PC:      w_sel_val = pc_debug;
            SEL_INSTR:   w_sel_val = instruction_debug;
            SEL_R0:      w_sel_val = debug_reg_0;
            SEL_R2:      w_sel_val = debug_reg_2;
            SEL_R3:      w_sel_val = debug_reg_3;
            SEL_R4:      w_sel_val = debug_reg_4;
            SEL_RETIRED: w_sel_val = r_retired;
            SEL_BLANK:   w_sel_val = 32'h0;
        endcase
    end

    // Nibble of the snapshot belonging to the current digit.
    always_comb begin
        w_nibble = r_snap[{r_idx, 2'b00} +: 4];
    end

    hex_to_seven_seg u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Prescaler, digit index and frame-boundary snapshot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= r_idx + 3'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_frame && !Freeze) begin
                r_snap <= w_sel_val;
            end
        end
    end

    // Retired-instruction counter: any PC change counts as one retirement.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev_pc <= '0;
            r_retired <= '0;
        end else begin
            r_prev_pc <= pc_debug;
            if (pc_debug != r_prev_pc) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // Registered display drive; blanking follows live Sel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg;
            r_an  <= (sel_e'(Sel) == SEL_BLANK) ? AN_OFF : ~(8'd1 << r_idx);
            r_dp  <= !((r_idx == 3'd0) && Freeze);
        end
    end

    assign Seg = r_seg;
    assign An  = r_an;
    assign Dp  = r_dp;

endmodule
